// File: rtl/bcd_display_formatter_if.sv
// Handshake and result bundle between a controller and the BCD display formatter.
// The master side requests conversions; the slave side is the formatter itself.
interface bcd_display_formatter_if #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 6
);
   logic                  iniciar;
   logic                  com_sinal;
   logic [WIDTH-1:0]      entrada;
   logic                  ocupado;
   logic                  pronto;
   logic                  estouro;
   logic [4*DIGITS-1:0]   saida;

   modport master (
      output iniciar, com_sinal, entrada,
      input  ocupado, pronto, estouro, saida
   );

   modport slave (
      input  iniciar, com_sinal, entrada,
      output ocupado, pronto, estouro, saida
   );
endinterface

// File: rtl/bcd_display_formatter.sv
// Sequential binary to display-code converter (double dabble) feeding
// seven-segment decoders. Each 4-bit field of saida: 0-9 digit, 10 minus, 15 blank.
// DIGITS-1 low positions hold magnitude digits; the minus sign floats just
// above the most significant digit. An overflowing value shows a dash row.
module bcd_display_formatter #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 6
) (
   input logic                    clock,
   input logic                    reset_n,
   bcd_display_formatter_if.slave bus
);

   localparam int NB = DIGITS - 1;          // magnitude digit count
   localparam int CW = $clog2(WIDTH + 1);   // shift counter width

   typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

   state_t                state_reg,   state_next;
   logic [WIDTH-1:0]      mag_reg,     mag_next;
   logic [4*NB-1:0]       bcd_reg,     bcd_next;
   logic                  ovf_reg,     ovf_next;
   logic                  sign_reg,    sign_next;
   logic [CW-1:0]         count_reg,   count_next;
   logic [4*DIGITS-1:0]   saida_reg,   saida_next;
   logic                  estouro_reg, estouro_next;
   logic                  pronto_reg,  pronto_next;
   logic                  ocupado_reg, ocupado_next;

   logic [4*NB-1:0]       bcd_adj;
   logic [4*DIGITS-1:0]   fmt_word;
   logic [31:0]           msd_idx;
   logic                  cap_sign;
   logic [WIDTH-1:0]      cap_mag;

   // Sign is only honoured for two's complement input; the most negative value
   // negates to itself, which read as unsigned is exactly 2^(WIDTH-1).
   assign cap_sign = bus.com_sinal & bus.entrada[WIDTH-1];
   assign cap_mag  = cap_sign ? (~bus.entrada + WIDTH'(1)) : bus.entrada;

   // Add-3 correction of every BCD digit that would reach 10 or more after the shift.
   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_adj
         assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                     (bcd_reg[gi*4 +: 4] + 4'd3) : bcd_reg[gi*4 +: 4];
      end
   endgenerate

   // Locate the most significant nonzero digit; zero magnitude leaves it at 0 so "0" shows.
   always_comb begin
      msd_idx = '0;
      for (int i = 1; i < NB; i++) begin
         if (bcd_reg[4*i +: 4] != 4'd0) begin
            msd_idx = 32'(i);
         end
      end
   end

   // Display field per position: digits up to msd, minus just above it, blanks elsewhere.
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_fmt
         if (gi < NB) begin : g_digit
            assign fmt_word[gi*4 +: 4] =
               ovf_reg                                      ? 4'd10 :
               (32'(gi) <= msd_idx)                         ? bcd_reg[gi*4 +: 4] :
               (sign_reg && (32'(gi) == msd_idx + 32'd1))   ? 4'd10 : 4'd15;
         end else begin : g_top
            assign fmt_word[gi*4 +: 4] =
               ovf_reg                                      ? 4'd10 :
               (sign_reg && (32'(gi) == msd_idx + 32'd1))   ? 4'd10 : 4'd15;
         end
      end
   endgenerate

   // Next-state and datapath: capture in IDLE, WIDTH shift steps, one format step.
   always_comb begin
      state_next   = state_reg;
      mag_next     = mag_reg;
      bcd_next     = bcd_reg;
      ovf_next     = ovf_reg;
      sign_next    = sign_reg;
      count_next   = count_reg;
      saida_next   = saida_reg;
      estouro_next = estouro_reg;
      pronto_next  = 1'b0;
      ocupado_next = ocupado_reg;
      case (state_reg)
         IDLE: begin
            if (bus.iniciar) begin
               sign_next    = cap_sign;
               mag_next     = cap_mag;
               bcd_next     = '0;
               ovf_next     = 1'b0;
               count_next   = '0;
               ocupado_next = 1'b1;
               state_next   = SHIFT;
            end
         end
         SHIFT: begin
            mag_next   = {mag_reg[WIDTH-2:0], 1'b0};
            bcd_next   = {bcd_adj[4*NB-2:0], mag_reg[WIDTH-1]};
            ovf_next   = ovf_reg | bcd_adj[4*NB-1];
            count_next = count_reg + CW'(1);
            if (count_reg == CW'(WIDTH - 1)) begin
               state_next = FORMAT;
            end
         end
         FORMAT: begin
            saida_next   = fmt_word;
            estouro_next = ovf_reg;
            pronto_next  = 1'b1;
            ocupado_next = 1'b0;
            state_next   = IDLE;
         end
         default: begin
            state_next   = IDLE;
            ocupado_next = 1'b0;
         end
      endcase
   end

   // State and output registers; reset blanks the display and aborts any conversion.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= IDLE;
         mag_reg     <= '0;
         bcd_reg     <= '0;
         ovf_reg     <= 1'b0;
         sign_reg    <= 1'b0;
         count_reg   <= '0;
         saida_reg   <= {DIGITS{4'hF}};
         estouro_reg <= 1'b0;
         pronto_reg  <= 1'b0;
         ocupado_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         mag_reg     <= mag_next;
         bcd_reg     <= bcd_next;
         ovf_reg     <= ovf_next;
         sign_reg    <= sign_next;
         count_reg   <= count_next;
         saida_reg   <= saida_next;
         estouro_reg <= estouro_next;
         pronto_reg  <= pronto_next;
         ocupado_reg <= ocupado_next;
      end
   end

   assign bus.saida   = saida_reg;
   assign bus.estouro = estouro_reg;
   assign bus.pronto  = pronto_reg;
   assign bus.ocupado = ocupado_reg;

endmodule

// File: doc/bcd_display_formatter.md
Name: bcd_display_formatter

Overview:
- Sequential binary-to-digit-code converter sitting directly upstream of the seven-segment decoders.
- Takes a WIDTH-bit value, signed or unsigned, and converts it with iterative shift-add-3 (double dabble).
- Produces one 4-bit code per display position: 0-9 are digits, 10 is the minus sign, 15 is blank.
- Each 4-bit field drives one decoder instance unchanged.

Parameters:
- WIDTH, 16, width of input value.
- DIGITS, 6, number of display positions. The DIGITS-1 low positions hold magnitude digits; the sign shares the field.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous reset, active-low.
- iniciar  input  1  start request, sampled only in IDLE.
- com_sinal  input  1  1 = entrada is two's complement; 0 = unsigned. Sampled with iniciar.
- entrada  input  WIDTH  value to convert. Sampled with iniciar.
- ocupado  output  1  high while a conversion is in progress.
- pronto  output  1  one-cycle pulse when saida/estouro update.
- estouro  output  1  last result did not fit in DIGITS-1 digits.
- saida  output  4*DIGITS  digit codes. Position 0 (least significant) is saida[3:0].

Behaviour:
- Reset (async, reset_n=0):
  - State=IDLE; ocupado=0, pronto=0, estouro=0.
  - saida = all fields 15 (all displays blank).
  - Internal shift/BCD registers cleared.
  - Reset mid-conversion aborts it; no pronto is issued.
- States: IDLE, SHIFT, FORMAT.
- IDLE:
  - On an edge with iniciar=1, capture sign = com_sinal & entrada[WIDTH-1].
  - Capture magnitude = sign ? -entrada : entrada, as WIDTH-bit unsigned. -2^(WIDTH-1) yields 2^(WIDTH-1) exactly.
  - Clear the BCD accumulator (DIGITS-1 digits) and the overflow flag; count=0.
  - Go to SHIFT; ocupado=1 from that edge.
- SHIFT, each edge:
  - Every BCD digit >=5 gets +3.
  - Then shift {overflow_carry, BCD, magnitude} left by 1.
  - A 1 shifted out of the top BCD digit sets the sticky overflow flag.
  - count++. After WIDTH edges, go to FORMAT.
- FORMAT, one edge:
  - Update saida, set estouro=overflow, pulse pronto=1 for exactly one cycle.
  - ocupado=0; return to IDLE.
- Latency: iniciar sampled at edge 0 → saida/pronto valid after edge WIDTH+1 (17 cycles for WIDTH=16). Back-to-back starts are accepted from the cycle pronto is high.
- Formatting rules:
  - Let m = index of the most significant nonzero BCD digit. Magnitude 0 gives m=0 and shows "0".
  - Positions 0..m carry BCD digits.
  - Positions above m are 15 (leading-zero blanking).
  - If sign=1, position m+1 is 10 (minus). m+1 <= DIGITS-1 always holds, so the minus always fits.
  - Top position (DIGITS-1) is 15 when unused.
  - Negative zero is impossible: magnitude 0 forces sign=0.
- Overflow: if overflow is set, all DIGITS positions = 10 (dash row) and estouro=1. The sign is ignored.
- Ignored inputs:
  - iniciar during SHIFT/FORMAT is ignored and not queued.
  - entrada/com_sinal changes after capture have no effect.
- Output stability: saida/estouro hold the last result until the next FORMAT edge or reset. There are no glitches between updates (all outputs registered).
- com_sinal=0 with entrada MSB=1: treated as a large positive value, no minus.

Test Plan:
- Reset: reset_n=0 asynchronously mid-cycle → saida=24'hFFFFFF, ocupado=0, pronto=0, estouro=0 immediately; outputs stay there after release.
- Unsigned: entrada=16'd1234, com_sinal=0, iniciar pulse → ocupado high 17 cycles, single pronto, saida=24'hFF1234.
- Unsigned edge cases: entrada=0 → 24'hFFFFF0. entrada=16'hFFFF → 24'hF65535.
- Signed: entrada=16'hFFF9 (−7), com_sinal=1 → 24'hFFFFA7.
- Signed extreme: entrada=16'h8000, com_sinal=1 → 24'hA32768. Same input with com_sinal=0 → 24'hF32768.
- Protocol: iniciar held high and entrada toggled during conversion → exactly one pronto, result from the captured value. reset_n asserted at cycle 8 of conversion → blank, no pronto, next start converts correctly.
- Overflow (DIGITS=4, WIDTH=16): unsigned 1000 → saida=16'hAAAA, estouro=1. Then 999 → 16'hF999, estouro=0. Then signed −999 → 16'hA999.
